// File: rtl/mem_pkg.sv
// Shared types and helpers for the synchronous word memory with clear engine.
package mem_pkg;

   // Clear-engine state: CLEAR walks the array writing zeros, IDLE serves the host.
   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } clr_state_e;

   // Number of words addressed by an address bus of the given width.
   function automatic int unsigned depth_of(input int unsigned addr_size);
      return 32'd1 << addr_size;
   endfunction

endpackage

// File: rtl/mem_clr_fsm.sv
// Clear sequencer: owns the state register, the clear address counter and busy.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   CLEAR | zeroing mem[clr_addr] each edge; host reads/writes refused
//   IDLE  | array owned by the host; clr_req_i starts a new clear pass
//
module mem_clr_fsm
   import mem_pkg::*;
#(
   parameter int ADDR_SIZE = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr_req_i,
   output logic                 clr_we_o,
   output logic [ADDR_SIZE-1:0] clr_addr_o,
   output logic                 accept_o,
   output logic                 busy_o
);

   clr_state_e           state_q, state_d;
   logic [ADDR_SIZE-1:0] clr_addr_q, clr_addr_d;
   logic                 busy_q, busy_d;

   // Next-state: walk addresses in CLEAR, leave after the last one; IDLE waits for a request.
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      busy_d     = busy_q;
      case (state_q)
         CLEAR: begin
            // The counter wraps to zero on its own after the top address.
            clr_addr_d = clr_addr_q + ADDR_SIZE'(1);
            if (&clr_addr_q) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         IDLE: begin
            if (clr_req_i) begin
               state_d    = CLEAR;
               clr_addr_d = '0;
               busy_d     = 1'b1;
            end
         end
         default: begin
            state_d    = CLEAR;
            clr_addr_d = '0;
            busy_d     = 1'b1;
         end
      endcase
   end

   // State register; reset restarts the clear pass from address zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         busy_q     <= busy_d;
      end
   end

   // Nothing touches the array during a reset cycle, neither clear nor host.
   assign clr_we_o   = (state_q == CLEAR) && rst_n;
   assign accept_o   = (state_q == IDLE) && rst_n;
   assign clr_addr_o = clr_addr_q;
   assign busy_o     = busy_q;

endmodule

// File: rtl/mem_sync_clr.sv
// Single-clock word memory with lane-masked writes, registered reads,
// optional output stage and a sequential zeroing engine.
module mem_sync_clr
   import mem_pkg::*;
#(
   parameter int WORD_SIZE   = 8,
   parameter int ADDR_SIZE   = 3,
   parameter int LANES       = 1,
   parameter int OUT_REG     = 0,
   parameter int WRITE_FIRST = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 wena,
   input  logic [ADDR_SIZE-1:0] w_addr,
   input  logic [WORD_SIZE-1:0] w_word,
   input  logic [LANES-1:0]     w_mask,
   input  logic                 rena,
   input  logic [ADDR_SIZE-1:0] r_addr,
   output logic [WORD_SIZE-1:0] r_word,
   output logic                 r_valid,
   output logic                 busy
);

   localparam int LANE_W   = WORD_SIZE / LANES;
   localparam int ADDR_MAX = int'(depth_of(ADDR_SIZE));
   localparam bit WF       = (WRITE_FIRST != 0);

   if (WORD_SIZE % LANES != 0) begin : g_bad_lanes
      $error("mem_sync_clr: WORD_SIZE must be a multiple of LANES");
   end
   if (ADDR_SIZE < 1) begin : g_bad_addr
      $error("mem_sync_clr: ADDR_SIZE must be at least 1");
   end
   if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_outreg
      $error("mem_sync_clr: OUT_REG must be 0 or 1");
   end

   logic                 clr_we;
   logic [ADDR_SIZE-1:0] clr_addr;
   logic                 accept;

   mem_clr_fsm #(
      .ADDR_SIZE (ADDR_SIZE)
   ) u_clr_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_req_i  (clr),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr),
      .accept_o   (accept),
      .busy_o     (busy)
   );

   logic [WORD_SIZE-1:0] mem_q [0:ADDR_MAX-1];

   logic [WORD_SIZE-1:0] wr_merged;
   logic [WORD_SIZE-1:0] rd_old;
   logic [WORD_SIZE-1:0] rd_word_d;
   logic                 wr_go;
   logic                 rd_go;
   logic                 collide;

   // Build the post-write word: masked lanes from w_word, the rest from the array.
   always_comb begin
      rd_old    = mem_q[r_addr];
      wr_merged = mem_q[w_addr];
      for (int l = 0; l < LANES; l++) begin
         if (w_mask[l]) begin
            wr_merged[l*LANE_W +: LANE_W] = w_word[l*LANE_W +: LANE_W];
         end
      end
   end

   // An all-zero mask is treated as no write so it never counts as a collision.
   assign wr_go     = accept && wena && (|w_mask);
   assign rd_go     = accept && rena;
   assign collide   = wr_go && (w_addr == r_addr);
   assign rd_word_d = (WF && collide) ? wr_merged : rd_old;

   // Array write port; the clear engine and the host never own it in the same cycle.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[clr_addr] <= '0;
      end else if (wr_go) begin
         mem_q[w_addr] <= wr_merged;
      end
   end

   logic [WORD_SIZE-1:0] rd_word_q;
   logic                 rd_valid_q;

   // First read stage: capture the word and flag a completed read for one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_word_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_go;
         if (rd_go) begin
            rd_word_q <= rd_word_d;
         end
      end
   end

   if (OUT_REG == 1) begin : g_out_reg
      logic [WORD_SIZE-1:0] out_word_q;
      logic                 out_valid_q;

      // Output stage keeps running during a clear so a read issued with clr still lands.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
         end else begin
            out_valid_q <= rd_valid_q;
            if (rd_valid_q) begin
               out_word_q <= rd_word_q;
            end
         end
      end

      assign r_word  = out_word_q;
      assign r_valid = out_valid_q;
   end else begin : g_no_out_reg
      assign r_word  = rd_word_q;
      assign r_valid = rd_valid_q;
   end

endmodule
